puneh_mem_responder: RTL and testbench

- Memory-side responder for the PUNEH CPU bus. It answers the CPU's readMEM/writeMEM/addrBus/dataBusOut requests and drives the CPU's dataBusIn.
- Contains a single-port word RAM, plus a small memory-mapped I/O window above IO_BASE: a TX FIFO drained over a valid/ready stream, a status register and a free-running cycle counter.
- Sits between the PUNEH top and the testbench/system.

---
 rtl/puneh_mem_responder.sv | 129 ++++++++++++
 tb/tb_puneh_mem_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/puneh_mem_responder.sv
// Memory-side responder for the PUNEH CPU bus: word RAM plus an I/O window
// holding a TX FIFO (valid/ready drained), a status register and a cycle counter.
module puneh_mem_responder #(
  parameter int          MEM_AW     = 10,
  parameter logic [15:0] IO_BASE    = 16'hFF00,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        readMEM,
  input  logic        writeMEM,
  input  logic [15:0] addrBus,
  input  logic [15:0] dataBusOut,
  output logic [15:0] dataBusIn,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bus_err
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [15:0]       ram [2**MEM_AW];
  logic [15:0]       fifoMem [FIFO_DEPTH];
  logic [PW-1:0]     rdPtr;
  logic [PW-1:0]     wrPtr;
  logic [CW-1:0]     count;
  logic              ovf;
  logic [15:0]       cycleCnt;

  logic              isIo;
  logic [15:0]       ioOff;
  logic [MEM_AW-1:0] ramIdx;
  logic              rdReq;
  logic              conflict;
  logic              fifoFull;
  logic              fifoEmpty;
  logic              pop;
  logic              pushReq;
  logic              pushOk;
  logic              ovfSet;
  logic              statusWr;
  logic [15:0]       statusWord;
  logic [15:0]       ioRdata;

  // Address decode and request qualification; a simultaneous read+write
  // keeps only the write and flags the bus error.
  always_comb begin
    isIo     = (addrBus >= IO_BASE);
    ioOff    = addrBus - IO_BASE;
    ramIdx   = addrBus[MEM_AW-1:0];
    rdReq    = readMEM & ~writeMEM;
    conflict = readMEM & writeMEM;
  end

  // FIFO control: a pop in the same cycle frees room for a push into a full FIFO.
  always_comb begin
    fifoFull  = (count == CW'(FIFO_DEPTH));
    fifoEmpty = (count == '0);
    pop       = ~fifoEmpty & tx_ready;
    pushReq   = writeMEM & isIo & (ioOff == 16'd0);
    pushOk    = pushReq & (~fifoFull | pop);
    ovfSet    = pushReq & fifoFull & ~pop;
    statusWr  = writeMEM & isIo & (ioOff == 16'd1);
  end

  always_comb begin
    statusWord = {7'd0, 5'(count), bus_err, ovf, fifoFull, fifoEmpty};
    case (ioOff)
      16'd1:   ioRdata = statusWord;
      16'd2:   ioRdata = cycleCnt;
      default: ioRdata = 16'd0;
    endcase
  end

  assign tx_valid = ~fifoEmpty;
  assign tx_data  = fifoEmpty ? 16'd0 : fifoMem[rdPtr];

  // Storage arrays carry no reset; RAM contents survive rst.
  always_ff @(posedge clk) begin
    if (!rst && writeMEM && !isIo) begin
      ram[ramIdx] <= dataBusOut;
    end
    if (!rst && pushOk) begin
      fifoMem[wrPtr] <= dataBusOut;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dataBusIn <= 16'd0;
      rdPtr     <= '0;
      wrPtr     <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      bus_err   <= 1'b0;
      cycleCnt  <= 16'd0;
    end else begin
      if (rdReq) begin
        dataBusIn <= isIo ? ioRdata : ram[ramIdx];
      end
      if (pushOk) begin
        wrPtr <= wrPtr + PW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PW'(1);
      end
      case ({pushOk, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Set events win over a clear written in the same cycle.
      if (ovfSet) begin
        ovf <= 1'b1;
      end else if (statusWr && dataBusOut[2]) begin
        ovf <= 1'b0;
      end
      if (conflict) begin
        bus_err <= 1'b1;
      end else if (statusWr && dataBusOut[3]) begin
        bus_err <= 1'b0;
      end
      cycleCnt <= cycleCnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_puneh_mem_responder.sv
// Scoreboard bench for puneh_mem_responder: a queue/array reference model predicts
// read data and TX stream contents; a monitor process pops and compares.
module tb_puneh_mem_responder;

  localparam int DEPTH = 4;
  localparam int MEMW  = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        readMEM;
  logic        writeMEM;
  logic [15:0] addrBus;
  logic [15:0] dataBusOut;
  logic [15:0] dataBusIn;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        bus_err;

  always #5 clk = ~clk;

  puneh_mem_responder #(
    .MEM_AW(10),
    .IO_BASE(16'hFF00),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .readMEM(readMEM),
    .writeMEM(writeMEM),
    .addrBus(addrBus),
    .dataBusOut(dataBusOut),
    .dataBusIn(dataBusIn),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .bus_err(bus_err)
  );

  // Reference model state
  logic [15:0] ramModel [MEMW];
  logic [15:0] fifoModel [$];
  logic        ovfModel;
  logic        errModel;
  logic [15:0] cycModel;

  // Scoreboard queues
  logic [15:0] rdQ [$];
  logic [15:0] txQ [$];

  int nCompared   = 0;
  int nMismatched = 0;

  // Monitor bookkeeping
  int          prevKind   = 0;
  logic [15:0] heldData   = 16'd0;
  logic [15:0] expData    = 16'd0;
  logic        prevStall  = 1'b0;
  logic [15:0] prevTxData = 16'd0;

  task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Drive one bus cycle, advance the model by that cycle, then check sticky/flag outputs.
  task automatic applyStimulus(input logic r, input logic w, input logic [15:0] a,
                               input logic [15:0] d, input logic rdy, input logic rs);
    logic        isIo;
    logic [15:0] off;
    logic [15:0] exp;
    int          sz;
    logic        doPop;
    logic        doPush;
    logic        ovfEv;
    logic        stWr;
    rst        = rs;
    readMEM    = r;
    writeMEM   = w;
    addrBus    = a;
    dataBusOut = d;
    tx_ready   = rdy;
    if (rs) begin
      fifoModel.delete();
      txQ.delete();
      ovfModel = 1'b0;
      errModel = 1'b0;
      cycModel = 16'd0;
    end else begin
      isIo  = (a >= 16'hFF00);
      off   = a - 16'hFF00;
      sz    = fifoModel.size();
      doPop = (sz != 0) && rdy;
      if (r && !w) begin
        exp = 16'd0;
        if (!isIo) begin
          exp = ramModel[int'(a) % MEMW];
        end else if (off == 16'd1) begin
          exp[0]   = (sz == 0);
          exp[1]   = (sz == DEPTH);
          exp[2]   = ovfModel;
          exp[3]   = errModel;
          exp[8:4] = 5'(sz);
        end else if (off == 16'd2) begin
          exp = cycModel;
        end
        rdQ.push_back(exp);
      end
      doPush = w && isIo && (off == 16'd0);
      ovfEv  = doPush && (sz == DEPTH) && !doPop;
      stWr   = w && isIo && (off == 16'd1);
      if (doPop) void'(fifoModel.pop_front());
      if (doPush && !ovfEv) begin
        fifoModel.push_back(d);
        txQ.push_back(d);
      end
      if (ovfEv) ovfModel = 1'b1;
      else if (stWr && d[2]) ovfModel = 1'b0;
      if (r && w) errModel = 1'b1;
      else if (stWr && d[3]) errModel = 1'b0;
      if (w && !isIo) ramModel[int'(a) % MEMW] = d;
      cycModel = cycModel + 16'd1;
    end
    @(posedge clk);
    #1;
    checkOutput("bus_err", 16'(bus_err), 16'(errModel));
    checkOutput("tx_valid", 16'(tx_valid), 16'(fifoModel.size() != 0));
  endtask

  // Monitor: mid-cycle, check read data returned for the previous cycle and TX handshakes.
  initial begin
    forever begin
      @(negedge clk);
      case (prevKind)
        1: begin
          if (rdQ.size() == 0) begin
            checkOutput("read queue has entry", 16'd0, 16'd1);
          end else begin
            expData = rdQ.pop_front();
            checkOutput("read data", dataBusIn, expData);
            heldData = expData;
          end
        end
        2: begin
          checkOutput("reset data", dataBusIn, 16'd0);
          heldData = 16'd0;
        end
        3: checkOutput("hold data", dataBusIn, heldData);
        default: ;
      endcase
      if (prevStall) checkOutput("tx_data stable on stall", tx_data, prevTxData);
      if (!rst && tx_valid && tx_ready) begin
        if (txQ.size() == 0) checkOutput("tx queue has entry", 16'd0, 16'd1);
        else checkOutput("tx_data", tx_data, txQ.pop_front());
      end
      prevStall  = !rst && tx_valid && !tx_ready;
      prevTxData = tx_data;
      prevKind   = rst ? 2 : ((readMEM && !writeMEM) ? 1 : 3);
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          sel;
    int          op;
    logic [15:0] a;
    logic        r;
    logic        w;

    applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 1);
    applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 1);

    // Give every RAM word a defined value so random reads are predictable.
    for (int i = 0; i < MEMW; i++) applyStimulus(0, 1, 16'(i), 16'($urandom), 0, 0);

    // Write, read back, aliased read.
    applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 1);
    applyStimulus(0, 1, 16'h0003, 16'hA5A5, 0, 0);
    applyStimulus(1, 0, 16'h0003, 16'h0000, 0, 0);
    applyStimulus(1, 0, 16'h0403, 16'h0000, 0, 0);
    applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 0);

    // Back-to-back read-after-write, then idle hold.
    applyStimulus(0, 1, 16'h0010, 16'h1234, 0, 0);
    applyStimulus(1, 0, 16'h0010, 16'h0000, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 0);

    // Overflow a stalled FIFO, read STATUS, then drain.
    for (int i = 1; i <= 5; i++) applyStimulus(0, 1, 16'hFF00, 16'(i), 0, 0);
    applyStimulus(1, 0, 16'hFF01, 16'h0000, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 16'h0000, 16'h0000, 1, 0);
    applyStimulus(1, 0, 16'hFF01, 16'h0000, 0, 0);

    // Push into full FIFO while popping: no overflow.
    applyStimulus(0, 1, 16'hFF01, 16'h0004, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 16'hFF00, 16'(16'h0011 + i), 0, 0);
    applyStimulus(0, 1, 16'hFF00, 16'h00AA, 1, 0);
    applyStimulus(1, 0, 16'hFF01, 16'h0000, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 16'h0000, 16'h0000, 1, 0);

    // Read+write conflict, then clear bus_err through STATUS.
    applyStimulus(1, 1, 16'h0020, 16'h7777, 0, 0);
    applyStimulus(1, 0, 16'h0020, 16'h0000, 0, 0);
    applyStimulus(1, 0, 16'hFF01, 16'h0000, 0, 0);
    applyStimulus(0, 1, 16'hFF01, 16'h0008, 0, 0);
    applyStimulus(1, 0, 16'hFF01, 16'h0000, 0, 0);

    // Cycle counter after reset; reset in the middle of a drain.
    applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 0);
    applyStimulus(1, 0, 16'hFF02, 16'h0000, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 16'hFF00, 16'(16'h0100 + i), 0, 0);
    applyStimulus(0, 0, 16'h0000, 16'h0000, 1, 0);
    applyStimulus(0, 0, 16'h0000, 16'h0000, 1, 1);
    applyStimulus(1, 0, 16'hFF01, 16'h0000, 1, 0);
    applyStimulus(1, 0, 16'hFF02, 16'h0000, 1, 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 99);
      if (sel < 55) a = 16'($urandom_range(0, 16'hFEFF));
      else if (sel < 95) begin
        op = $urandom_range(0, 5);
        a  = 16'hFF00 + 16'((op > 3) ? 0 : op);
      end else a = 16'hFF00 + 16'($urandom_range(4, 255));
      op = $urandom_range(0, 19);
      r  = (op == 0) || (op >= 1 && op <= 8);
      w  = (op == 0) || (op >= 9 && op <= 16);
      applyStimulus(r, w, a, 16'($urandom), ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 299) == 0));
    end

    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 16'h0000, 16'h0000, 1, 0);
    checkOutput("read queue drained", 16'(rdQ.size()), 16'd0);
    checkOutput("tx queue drained", 16'(txQ.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
